// File: rtl/multicycle_mul_unit.sv
// Iterative multiplier for the EX stage: consumes CHUNK_W multiplier bits per cycle
// and returns the low DATA_W bits of the product after DATA_W/CHUNK_W busy cycles.
module multicycle_mul_unit #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int STEPS  = DATA_W / CHUNK_W;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SH_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   a_reg_r;
    logic [DATA_W-1:0]   b_reg_r;
    logic [DATA_W-1:0]   acc_r;
    logic [DATA_W-1:0]   result_r;
    logic [STEP_W-1:0]   step_r;
    logic                done_r;

    logic [SH_W-1:0]     shift_s;
    logic [CHUNK_W-1:0]  chunk_s;
    logic [DATA_W-1:0]   partial_s;
    logic [DATA_W-1:0]   acc_next_s;

    // Partial product of the current multiplier chunk, aligned to its bit position
    always_comb begin
        shift_s    = SH_W'(step_r) * SH_W'(CHUNK_W);
        chunk_s    = b_reg_r[shift_s +: CHUNK_W];
        partial_s  = (a_reg_r * DATA_W'(chunk_s)) << shift_s;
        acc_next_s = acc_r + partial_s;
    end

    // Hazard request: hold the MUL in EX from capture until the product is ready
    always_comb begin
        stall_req = 1'b0;
        if (rst || flush) begin
            stall_req = 1'b0;
        end else if (state_r == BUSY) begin
            stall_req = 1'b1;
        end else if ((state_r == IDLE) && start) begin
            stall_req = 1'b1;
        end else begin
            stall_req = 1'b0;
        end
    end

    // Completion strobe is registered; a squash or reset in that cycle suppresses it
    always_comb begin
        done = 1'b0;
        if (rst || flush) begin
            done = 1'b0;
        end else begin
            done = done_r;
        end
    end

    assign result = result_r;

    // Control FSM with operand capture, accumulation and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_reg_r  <= {DATA_W{1'b0}};
            b_reg_r  <= {DATA_W{1'b0}};
            acc_r    <= {DATA_W{1'b0}};
            result_r <= {DATA_W{1'b0}};
            step_r   <= {STEP_W{1'b0}};
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start && !flush) begin
                        a_reg_r <= operand_a;
                        b_reg_r <= operand_b;
                        acc_r   <= {DATA_W{1'b0}};
                        step_r  <= {STEP_W{1'b0}};
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        step_r  <= {STEP_W{1'b0}};
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        acc_r  <= acc_next_s;
                        step_r <= step_r + STEP_W'(1);
                        if (step_r == LAST_STEP) begin
                            result_r <= acc_next_s;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            done_r  <= 1'b0;
                            state_r <= BUSY;
                        end
                    end
                end
                DONE: begin
                    // A start still asserted here belongs to the instruction just retired
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
